// File: rtl/pool_ctrl.sv
// pool_ctrl: row/bit-plane/kernel-row sequencer for one pooling unit.
// Optional macro POOL_CTRL_PERF_EN adds the stall_cnt and cyc_cnt performance counters.
`default_nettype none

// ============================================================================
//  Module      : pool_ctrl
//  Description : Issues activation reads and aligned clr/en/wr strobes
//                through an RD_LAT-deep delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_ctrl #(
    parameter int unsigned POOL_SIZE = 14,
    parameter int unsigned KER_SIZE  = 2,
    parameter int unsigned ACT_BITS  = 3,
    parameter int unsigned PAR_MAX   = 2,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(PAR_MAX+1)-1:0] par_num,
    input  logic [ADDR_W-1:0]            base_in,
    input  logic [ADDR_W-1:0]            base_out,
    input  logic                         rd_gnt,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic [PAR_MAX-1:0]           lane_en,
    output logic                         pool_clr,
    output logic                         pool_en,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         busy,
    output logic                         done
`ifdef POOL_CTRL_PERF_EN
    ,
    output logic [15:0]                  stall_cnt,
    output logic [15:0]                  cyc_cnt
`endif
);

    localparam int unsigned ROW_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam int unsigned BIT_W = (ACT_BITS  > 1) ? $clog2(ACT_BITS)  : 1;
    localparam int unsigned KER_W = (KER_SIZE  > 1) ? $clog2(KER_SIZE)  : 1;
    // Every stage except the output one; nonzero means data still in flight.
    localparam logic [RD_LAT-1:0] PEND_MASK = {RD_LAT{1'b1}} >> 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ROW_W-1:0]    r_row;
    logic [BIT_W-1:0]    r_bit;
    logic [KER_W-1:0]    r_ker;
    logic [ADDR_W-1:0]   r_base_in;
    logic [ADDR_W-1:0]   r_base_out;
    logic [PAR_MAX-1:0]  r_lane;
    logic [PAR_MAX-1:0]  w_lane_mask;
    logic [31:0]         w_lane_n;

    logic [RD_LAT-1:0]   r_dl_vld;
    logic [RD_LAT-1:0]   r_dl_first;
    logic [RD_LAT-1:0]   r_dl_last;
    logic [ROW_W-1:0]    r_dl_row [RD_LAT];
    logic [BIT_W-1:0]    r_dl_bit [RD_LAT];

    logic                w_accept;
    logic                w_issue;
    logic                w_grant;
    logic                w_last_rd;
    logic                w_pending;
    logic [ADDR_W-1:0]   w_rd_off;
    logic [ADDR_W-1:0]   w_wr_off;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_issue   = (r_state == ST_ISSUE);
    assign w_grant   = w_issue && rd_gnt;
    assign w_last_rd = (r_row == ROW_W'(POOL_SIZE - 1)) && (r_bit == BIT_W'(ACT_BITS - 1))
                    && (r_ker == KER_W'(KER_SIZE - 1));
    assign w_pending = |(r_dl_vld & PEND_MASK);

    // Clamp requested lane count into 1..PAR_MAX and expand to a thermometer mask.
    always_comb begin
        w_lane_n = 32'(par_num);
        if (w_lane_n == 32'd0)
            w_lane_n = 32'd1;
        else if (w_lane_n > PAR_MAX)
            w_lane_n = PAR_MAX;
        w_lane_mask = '0;
        for (int unsigned i = 0; i < PAR_MAX; i++)
            w_lane_mask[i] = (i < w_lane_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)                 w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (rd_gnt && w_last_rd)   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!w_pending)            w_state_nxt = ST_DONE;
            ST_DONE:                             w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Loop counters: kernel row innermost, then bit plane, then output row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row      <= '0;
            r_bit      <= '0;
            r_ker      <= '0;
            r_base_in  <= '0;
            r_base_out <= '0;
            r_lane     <= '0;
        end else if (w_accept) begin
            r_row      <= '0;
            r_bit      <= '0;
            r_ker      <= '0;
            r_base_in  <= base_in;
            r_base_out <= base_out;
            r_lane     <= w_lane_mask;
        end else if (w_grant) begin
            if (r_ker == KER_W'(KER_SIZE - 1)) begin
                r_ker <= '0;
                if (r_bit == BIT_W'(ACT_BITS - 1)) begin
                    r_bit <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_bit <= r_bit + 1'b1;
                end
            end else begin
                r_ker <= r_ker + 1'b1;
            end
        end
    end

    // Delay line aligns the datapath strobes with read data return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_vld   <= '0;
            r_dl_first <= '0;
            r_dl_last  <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_dl_row[i] <= '0;
                r_dl_bit[i] <= '0;
            end
        end else begin
            r_dl_vld[0]   <= w_grant;
            r_dl_first[0] <= (r_ker == '0);
            r_dl_last[0]  <= (r_ker == KER_W'(KER_SIZE - 1));
            r_dl_row[0]   <= r_row;
            r_dl_bit[0]   <= r_bit;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_dl_vld[i]   <= r_dl_vld[i-1];
                r_dl_first[i] <= r_dl_first[i-1];
                r_dl_last[i]  <= r_dl_last[i-1];
                r_dl_row[i]   <= r_dl_row[i-1];
                r_dl_bit[i]   <= r_dl_bit[i-1];
            end
        end
    end

    assign w_rd_off = ADDR_W'((32'(r_row) * KER_SIZE + 32'(r_ker)) * ACT_BITS + 32'(r_bit));
    assign w_wr_off = ADDR_W'(32'(r_dl_row[RD_LAT-1]) * ACT_BITS + 32'(r_dl_bit[RD_LAT-1]));

    assign rd_en    = w_issue;
    assign rd_addr  = w_issue ? (r_base_in + w_rd_off) : '0;
    assign pool_en  = r_dl_vld[RD_LAT-1];
    assign pool_clr = r_dl_vld[RD_LAT-1] && r_dl_first[RD_LAT-1];
    assign wr_en    = r_dl_vld[RD_LAT-1] && r_dl_last[RD_LAT-1];
    assign wr_addr  = wr_en ? (r_base_out + w_wr_off) : '0;
    assign busy     = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign done     = (r_state == ST_DONE);
    assign lane_en  = (r_state == ST_IDLE) ? '0 : r_lane;

`ifdef POOL_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            cyc_cnt   <= '0;
        end else if (w_accept) begin
            stall_cnt <= '0;
            cyc_cnt   <= '0;
        end else begin
            if (w_issue && !rd_gnt && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (busy && (cyc_cnt != 16'hFFFF))
                cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: randomized self-checking bench for pool_ctrl against a loop-order reference model.
`default_nettype none

// ============================================================================
//  Module      : tb_pool_ctrl
//  Description : Drives layers with random grants/bases and compares every
//                cycle against expectations derived from the layer loop nest.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_ctrl;

    localparam int P     = 14;
    localparam int K     = 2;
    localparam int A     = 3;
    localparam int PM    = 2;
    localparam int RL    = 1;
    localparam int AW    = 10;
    localparam int TOTAL = P * K * A;
    localparam int NWR   = P * A;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    par_num;
    logic [AW-1:0] base_in;
    logic [AW-1:0] base_out;
    logic          rd_gnt;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [PM-1:0] lane_en;
    logic          pool_clr;
    logic          pool_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
`ifdef POOL_CTRL_PERF_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   cyc_cnt;
`endif

    pool_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .par_num  (par_num),
        .base_in  (base_in),
        .base_out (base_out),
        .rd_gnt   (rd_gnt),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .lane_en  (lane_en),
        .pool_clr (pool_clr),
        .pool_en  (pool_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy),
        .done     (done)
`ifdef POOL_CTRL_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .cyc_cnt  (cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_done_cycle;

    bit            ev_pool [0:1023];
    bit            ev_clr  [0:1023];
    bit            ev_wr   [0:1023];
    logic [AW-1:0] ev_waddr[0:1023];

    // mode: 0 always granted, 1 grant low in cycles 2..4, 2 random grant.
    // noisy: random start pulses / input changes while the layer runs.
    task automatic run_layer(input int par, input int bin, input int bout, input int mode, input bit noisy);
        int idx, last_grant, stalls, busy_cyc, wr_seen, done_seen, n, r, b, k, rem;
        bit gnt, e_busy, e_done, e_rd, fin;
        logic [AW-1:0] e_raddr;
        logic [PM-1:0] lane;
        for (int i = 0; i < 1024; i++) begin
            ev_pool[i] = 0; ev_clr[i] = 0; ev_wr[i] = 0; ev_waddr[i] = '0;
        end
        n    = (par == 0) ? 1 : ((par > PM) ? PM : par);
        lane = PM'((1 << n) - 1);
        @(negedge clk);
        start = 1'b1; par_num = 2'(par); base_in = AW'(bin); base_out = AW'(bout); rd_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; last_grant = -100; stalls = 0; busy_cyc = 0; wr_seen = 0; done_seen = 0; fin = 0;
        last_done_cycle = -1;
        for (int c = 1; c < 600 && !fin; c++) begin
            e_rd   = (idx < TOTAL);
            e_busy = e_rd || (c <= last_grant + RL);
            e_done = !e_rd && (c == last_grant + RL + 1);
            r = idx / (A * K); rem = idx % (A * K); b = rem / K; k = rem % K;
            e_raddr = AW'(bin + (r * K + k) * A + b);
            checks++;
            if (rd_en !== e_rd) begin
                errors++; $display("FAIL rd_en c=%0d got %0b exp %0b", c, rd_en, e_rd);
            end
            if (e_rd) begin
                checks++;
                if (rd_addr !== e_raddr) begin
                    errors++; $display("FAIL rd_addr c=%0d got %0d exp %0d", c, rd_addr, e_raddr);
                end
            end
            checks++;
            if (busy !== e_busy) begin
                errors++; $display("FAIL busy c=%0d got %0b exp %0b", c, busy, e_busy);
            end
            checks++;
            if (done !== e_done) begin
                errors++; $display("FAIL done c=%0d got %0b exp %0b", c, done, e_done);
            end
            checks++;
            if (lane_en !== ((e_busy || e_done) ? lane : '0)) begin
                errors++; $display("FAIL lane_en c=%0d got %b exp %b", c, lane_en, (e_busy || e_done) ? lane : '0);
            end
            checks++;
            if ({pool_en, pool_clr, wr_en} !== {ev_pool[c], ev_clr[c], ev_wr[c]}) begin
                errors++;
                $display("FAIL strobes c=%0d got en/clr/wr %b%b%b exp %b%b%b", c, pool_en, pool_clr, wr_en,
                         ev_pool[c], ev_clr[c], ev_wr[c]);
            end
            if (ev_wr[c]) begin
                checks++;
                if (wr_addr !== ev_waddr[c]) begin
                    errors++; $display("FAIL wr_addr c=%0d got %0d exp %0d", c, wr_addr, ev_waddr[c]);
                end
            end
            if (e_busy) busy_cyc++;
            if (wr_en) wr_seen++;
            if (done) begin done_seen++; last_done_cycle = c; end
            if (!e_rd && c == last_grant + RL + 2) begin
                fin = 1;
            end else begin
                case (mode)
                    0:       gnt = 1'b1;
                    1:       gnt = !(c >= 2 && c <= 4);
                    default: gnt = ($urandom_range(0, 3) != 0);
                endcase
                rd_gnt = gnt;
                if (e_rd) begin
                    if (!gnt) stalls++;
                    else begin
                        ev_pool[c + RL]  = 1'b1;
                        ev_clr[c + RL]   = (k == 0);
                        ev_wr[c + RL]    = (k == K - 1);
                        ev_waddr[c + RL] = AW'(bout + r * A + b);
                        idx++;
                        if (idx == TOTAL) last_grant = c;
                    end
                end
                if (noisy) begin
                    start    = e_done || ($urandom_range(0, 3) == 0);
                    base_in  = AW'($urandom);
                    base_out = AW'($urandom);
                    par_num  = 2'($urandom);
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        checks++;
        if (!fin) begin
            errors++; $display("FAIL timeout layer did not finish got idx %0d exp %0d", idx, TOTAL);
        end
        checks++;
        if (wr_seen !== NWR) begin
            errors++; $display("FAIL write_count got %0d exp %0d", wr_seen, NWR);
        end
        checks++;
        if (done_seen !== 1) begin
            errors++; $display("FAIL done_count got %0d exp 1", done_seen);
        end
`ifdef POOL_CTRL_PERF_EN
        checks++;
        if (stall_cnt !== 16'(stalls)) begin
            errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, stalls);
        end
        checks++;
        if (cyc_cnt !== 16'(busy_cyc)) begin
            errors++; $display("FAIL cyc_cnt got %0d exp %0d", cyc_cnt, busy_cyc);
        end
`endif
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rd_en, busy, done, pool_en, pool_clr, wr_en} !== 6'b0 || lane_en !== '0
            || rd_addr !== '0 || wr_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd_en%b busy%b done%b en%b clr%b wr%b lane%b exp all 0",
                     rd_en, busy, done, pool_en, pool_clr, wr_en, lane_en);
        end
`ifdef POOL_CTRL_PERF_EN
        checks++;
        if (stall_cnt !== 16'd0 || cyc_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", stall_cnt, cyc_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        run_layer(1, 0, 0, 0, 1'b0);
        checks++;
        if (last_done_cycle !== 86) begin
            errors++; $display("FAIL nominal_done_cycle got %0d exp 86", last_done_cycle);
        end
    endtask

    task automatic test_stall();
        run_layer(1, 0, 0, 1, 1'b0);
        checks++;
        if (last_done_cycle !== 89) begin
            errors++; $display("FAIL stall_done_cycle got %0d exp 89", last_done_cycle);
        end
    endtask

    task automatic test_lanes();
        run_layer(0, 5, 100, 2, 1'b0);
        run_layer(2, 17, 3, 2, 1'b0);
        run_layer(3, 200, 900, 2, 1'b0);
    endtask

    task automatic test_wrap();
        run_layer(2, 1020, 1010, 0, 1'b0);
        run_layer(1, 1000, 1023, 2, 1'b0);
    endtask

    task automatic test_busy_start();
        run_layer(2, 40, 60, 2, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_layer(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 1023)), 2, 1'(i & 1));
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; par_num = 2'd2; base_in = 10'd7; base_out = 10'd9; rd_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, busy, done, pool_en, pool_clr, wr_en} !== 6'b0 || lane_en !== '0
            || rd_addr !== '0 || wr_addr !== '0) begin
            errors++;
            $display("FAIL async_reset got rd_en%b busy%b done%b en%b wr%b lane%b addr%0d exp all 0",
                     rd_en, busy, done, pool_en, wr_en, lane_en, rd_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_layer(1, 0, 0, 0, 1'b0);
        checks++;
        if (last_done_cycle !== 86) begin
            errors++; $display("FAIL after_reset_done_cycle got %0d exp 86", last_done_cycle);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; par_num = 2'd1; base_in = '0; base_out = '0; rd_gnt = 1'b1;
        test_reset();
        test_nominal();
        test_stall();
        test_lanes();
        test_wrap();
        test_busy_start();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
